// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding and
// the width of the reported failing-stage index.
package reset_seq_pkg;

  localparam int ERR_STAGE_W = 3;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_HOLD      = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_GAP       = 3'd4,
    ST_RUN       = 3'd5
  } state_e;

endpackage

// File: rtl/reset_sequencer_if.sv
// Bundle of lock/request/ack inputs and sequenced reset/status outputs between
// the reset sequencer (master) and the surrounding reset tree (slave).
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  import reset_seq_pkg::*;

  logic                   pll_locked;
  logic                   sw_reset_req;
  logic [NUM_STAGES-1:0]  stage_ack;
  logic [NUM_STAGES-1:0]  reset_out;
  logic                   seq_done;
  logic                   busy;
  logic                   timeout_err;
  logic [ERR_STAGE_W-1:0] err_stage;

  modport master (
    input  pll_locked, sw_reset_req, stage_ack,
    output reset_out, seq_done, busy, timeout_err, err_stage
  );

  modport slave (
    output pll_locked, sw_reset_req, stage_ack,
    input  reset_out, seq_done, busy, timeout_err, err_stage
  );

endinterface

// File: rtl/seq_counter.sv
// Up-counter with clear and enable plus a terminal-value compare; one instance
// times the hold, inter-stage gap and ack timeout of the sequencer.
module seq_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] term,
  output logic                 match
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match = (cnt_q == term);

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset domains in order after PLL lock, one stage per
// acknowledge, and re-asserts them all together on lock loss or software request.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGE_GAP   = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_in,
  reset_sequencer_if.master     sif
);

  localparam int IDX_W = $clog2(NUM_STAGES);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_STAGES-1:0]  reset_out_q, reset_out_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [ERR_STAGE_W-1:0] err_stage_q, err_stage_d;

  logic                   cnt_clr;
  logic                   cnt_en;
  logic [CNT_WIDTH-1:0]   cnt_term;
  logic                   cnt_match;

  seq_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_seq_counter (
    .clk   (clk),
    .rst   (reset_in),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (cnt_term),
    .match (cnt_match)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    reset_out_d   = reset_out_q;
    timeout_err_d = timeout_err_q;
    err_stage_d   = err_stage_q;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    cnt_term      = '0;

    // Lock loss outranks a software request; neither applies while already waiting for lock.
    if (!sif.pll_locked && state_q != ST_WAIT_LOCK) begin
      reset_out_d = '1;
      idx_d       = '0;
      cnt_clr     = 1'b1;
      state_d     = ST_WAIT_LOCK;
    end else if (sif.sw_reset_req && state_q != ST_WAIT_LOCK) begin
      reset_out_d   = '1;
      idx_d         = '0;
      cnt_clr       = 1'b1;
      timeout_err_d = 1'b0;
      state_d       = ST_HOLD;
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: begin
          if (sif.pll_locked) begin
            cnt_clr = 1'b1;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          cnt_term = CNT_WIDTH'(HOLD_CYCLES - 1);
          if (cnt_match) begin
            cnt_clr = 1'b1;
            state_d = ST_RELEASE;
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_RELEASE: begin
          reset_out_d[idx_q] = 1'b0;
          cnt_clr            = 1'b1;
          state_d            = ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          cnt_term = CNT_WIDTH'(ACK_TIMEOUT - 1);
          // A timed-out stage is treated as acked so the rest of the system still comes up.
          if (sif.stage_ack[idx_q] || cnt_match) begin
            if (!sif.stage_ack[idx_q] && !timeout_err_q) begin
              timeout_err_d = 1'b1;
              err_stage_d   = ERR_STAGE_W'(idx_q);
            end
            cnt_clr = 1'b1;
            if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_GAP;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_GAP: begin
          cnt_term = CNT_WIDTH'(STAGE_GAP - 1);
          if (cnt_match) begin
            idx_d   = idx_q + IDX_W'(1);
            cnt_clr = 1'b1;
            state_d = ST_RELEASE;
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_RUN: begin
          reset_out_d = '0;
        end
        default: begin
          reset_out_d = '1;
          idx_d       = '0;
          cnt_clr     = 1'b1;
          state_d     = ST_WAIT_LOCK;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q       <= ST_WAIT_LOCK;
      idx_q         <= '0;
      reset_out_q   <= '1;
      timeout_err_q <= 1'b0;
      err_stage_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      reset_out_q   <= reset_out_d;
      timeout_err_q <= timeout_err_d;
      err_stage_q   <= err_stage_d;
    end
  end

  assign sif.reset_out   = reset_out_q;
  assign sif.timeout_err = timeout_err_q;
  assign sif.err_stage   = err_stage_q;
  assign sif.seq_done    = (state_q == ST_RUN);
  assign sif.busy        = (state_q != ST_RUN);

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: directed bring-up scenarios followed by
// a randomized soak, checked against an event-time reference model.
module tb_reset_sequencer;

  localparam int NS      = 4;
  localparam int HOLD    = 4;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 255;

  logic clk;
  logic reset_in;

  reset_sequencer_if #(.NUM_STAGES(NS)) sif ();

  reset_sequencer #(
    .NUM_STAGES  (NS),
    .CNT_WIDTH   (16),
    .HOLD_CYCLES (HOLD),
    .STAGE_GAP   (GAP),
    .ACK_TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .sif      (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          edge_no;
    logic [NS-1:0] rst;
    logic        done;
    logic        busy;
    logic        terr;
    logic [2:0]  es;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;

  // Reference model: tracks absolute edge numbers at which the next release or
  // ack deadline falls, rather than a state/counter pair.
  bit          m_wait_lock;
  bit          m_run;
  bit          m_acking;
  int          m_k;
  int          m_drop_at;
  int          m_deadline;
  logic [NS-1:0] m_rst;
  bit          m_terr;
  logic [2:0]  m_es;

  task automatic model_edge(input bit r, input bit pll, input bit sw, input logic [NS-1:0] ack);
    if (r) begin
      m_wait_lock = 1; m_run = 0; m_acking = 0; m_k = 0;
      m_rst = '1; m_terr = 0; m_es = 0;
    end else if (!m_wait_lock && !pll) begin
      m_wait_lock = 1; m_run = 0; m_acking = 0; m_k = 0; m_rst = '1;
    end else if (!m_wait_lock && sw) begin
      m_run = 0; m_acking = 0; m_k = 0; m_rst = '1; m_terr = 0;
      m_drop_at = edge_n + HOLD + 1;
    end else if (m_wait_lock) begin
      if (pll) begin
        m_wait_lock = 0; m_k = 0; m_acking = 0;
        m_drop_at = edge_n + HOLD + 1;
      end
    end else if (!m_run) begin
      if (!m_acking && edge_n == m_drop_at) begin
        m_rst[m_k] = 1'b0;
        m_acking   = 1;
        m_deadline = edge_n + TIMEOUT;
      end else if (m_acking && (ack[m_k] || edge_n == m_deadline)) begin
        if (!ack[m_k] && !m_terr) begin
          m_terr = 1; m_es = 3'(m_k);
        end
        m_acking = 0;
        if (m_k == NS - 1) begin
          m_run = 1;
        end else begin
          m_k++;
          m_drop_at = edge_n + GAP + 1;
        end
      end
    end
  endtask

  task automatic cycle(input bit r, input bit pll, input bit sw, input logic [NS-1:0] ack);
    exp_t e;
    @(negedge clk);
    reset_in         = r;
    sif.pll_locked   = pll;
    sif.sw_reset_req = sw;
    sif.stage_ack    = ack;
    @(posedge clk);
    edge_n++;
    model_edge(r, pll, sw, ack);
    e.edge_no = edge_n;
    e.rst     = m_rst;
    e.done    = m_run;
    e.busy    = !m_run;
    e.terr    = m_terr;
    e.es      = m_es;
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are registered, so each negedge shows the result of the previous posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (sif.reset_out !== e.rst || sif.seq_done !== e.done || sif.busy !== e.busy ||
            sif.timeout_err !== e.terr || sif.err_stage !== e.es) begin
          errors++;
          $display("FAIL outputs@edge%0d: got rst=%b done=%b busy=%b terr=%b es=%0d, want rst=%b done=%b busy=%b terr=%b es=%0d",
                   e.edge_no, sif.reset_out, sif.seq_done, sif.busy, sif.timeout_err, sif.err_stage,
                   e.rst, e.done, e.busy, e.terr, e.es);
        end
      end
    end
  end

  initial begin
    int   mode;
    int   stuck;
    logic [NS-1:0] ack;
    bit   r, pll, sw;

    reset_in         = 1'b1;
    sif.pll_locked   = 1'b0;
    sif.sw_reset_req = 1'b0;
    sif.stage_ack    = '0;

    repeat (3) cycle(1, 0, 0, '0);

    // Clean bring-up with immediate acks.
    repeat (25) cycle(0, 1, 0, 4'hF);

    // Stage 2 never acks: timeout, yet stage 3 still released.
    cycle(1, 0, 0, '0);
    repeat (300) cycle(0, 1, 0, 4'b1011);

    // One-cycle lock loss in RUN, then full resequence.
    cycle(0, 0, 0, 4'hF);
    repeat (25) cycle(0, 1, 0, 4'hF);

    // Software pulse while waiting on stage 1's ack.
    cycle(0, 0, 0, '0);
    repeat (14) cycle(0, 1, 0, 4'b0001);
    cycle(0, 1, 1, 4'b0001);
    repeat (30) cycle(0, 1, 0, 4'hF);

    // Software request held for 10 cycles.
    repeat (10) cycle(0, 1, 1, 4'hF);
    repeat (30) cycle(0, 1, 0, 4'hF);

    // Create a timeout so err_stage is nonzero, then reset_in with sw during stage-1 GAP.
    cycle(0, 0, 0, '0);
    repeat (280) cycle(0, 1, 0, 4'b1101);
    cycle(0, 0, 0, '0);
    repeat (11) cycle(0, 1, 0, 4'hF);
    cycle(1, 1, 1, 4'hF);
    repeat (25) cycle(0, 1, 0, 4'hF);

    // Randomized soak.
    mode  = 0;
    stuck = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 300 == 0) begin
        mode  = $urandom_range(0, 2);
        stuck = $urandom_range(0, NS - 1);
      end
      r   = ($urandom_range(0, 599) == 0);
      pll = ($urandom_range(0, 249) != 0);
      sw  = ($urandom_range(0, 199) == 0);
      case (mode)
        0:       for (int b = 0; b < NS; b++) ack[b] = ($urandom_range(0, 3) == 0);
        1:       ack = '1;
        default: begin
          ack = '1;
          ack[stuck] = 1'b0;
        end
      endcase
      cycle(r, pll, sw, ack);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
